fifo_write_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Imported by the arbiter top and its priority picker.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request bit at or
// above ptr, wrapping from the top index back to zero.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk downward so the lowest offset from ptr wins last.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked scheduler for the single write port
// of the FIFO buffer, with full backpressure and a burst cap.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int IW         = clog2(NUM_REQ)
) (
  input  logic                          write_clock,
  input  logic                          write_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          write_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          found;
  logic [IW-1:0] pick;
  logic          xfer;
  logic          cap_hit;
  logic          release_now;

  rr_priority_picker #(
    .N(NUM_REQ)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick)
  );

  always_comb begin
    req_ready    = '0;
    write_enable = 1'b0;
    write_data   = '0;
    xfer         = 1'b0;
    if (state_q == ST_GRANT) begin
      req_ready[gid_q] = ~write_full;
      xfer             = req_valid[gid_q] & ~write_full;
      write_enable     = xfer;
      if (xfer) begin
        write_data = req_data[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cap_hit     = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign release_now = xfer & (req_last[gid_q] | cap_hit);

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          gid_d   = pick;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) cnt_d = cnt_q + 8'd1;
        if (release_now) begin
          state_d = ST_IDLE;
          if (gid_q == IW'(NUM_REQ - 1)) ptr_d = '0;
          else                           ptr_d = gid_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gid_q;
  assign busy     = (state_q == ST_GRANT);

endmodule
